// File: rtl/psram_arbiter.sv
// Round-robin arbiter and transaction sequencer that lets two masters share one PSRAM PHY controller.
// A grant is held for a whole burst. Hung bursts are aborted. A minimum idle gap separates transactions.
module psram_arbiter #(
  parameter int ADDR_W   = 24,
  parameter int DATA_W   = 32,
  parameter int LEN_W    = 4,
  parameter int IDLE_GAP = 2,
  parameter int TIMEOUT  = 1024
) (
  input  logic              clk,
  input  logic              reset_n,
  // port 0 (CPU data bus)
  input  logic              r0_cmd_valid,
  output logic              r0_cmd_ready,
  input  logic              r0_cmd_write,
  input  logic [ADDR_W-1:0] r0_cmd_addr,
  input  logic [LEN_W-1:0]  r0_cmd_len,
  input  logic              r0_wdata_valid,
  output logic              r0_wdata_ready,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_rdata_valid,
  output logic [DATA_W-1:0] r0_rdata,
  output logic              r0_done,
  output logic              r0_err,
  // port 1 (DMA / peripheral master)
  input  logic              r1_cmd_valid,
  output logic              r1_cmd_ready,
  input  logic              r1_cmd_write,
  input  logic [ADDR_W-1:0] r1_cmd_addr,
  input  logic [LEN_W-1:0]  r1_cmd_len,
  input  logic              r1_wdata_valid,
  output logic              r1_wdata_ready,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_rdata_valid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              r1_done,
  output logic              r1_err,
  // PHY controller side
  output logic              mem_cmd_valid,
  input  logic              mem_cmd_ready,
  output logic              mem_cmd_write,
  output logic [ADDR_W-1:0] mem_cmd_addr,
  output logic [LEN_W-1:0]  mem_cmd_len,
  output logic              mem_wdata_valid,
  input  logic              mem_wdata_ready,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rdata_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic              mem_abort,
  // observability
  output logic [1:0]        dbg_state,
  output logic              dbg_grant
);

  // Valid/ready semantics on every channel: a command or beat transfers on a rising
  // edge where valid and ready are both high. Valid must not wait for ready, and once
  // raised it stays up until the transfer. Read beats and done/err are strobes.

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam int GAP_W = $clog2(IDLE_GAP + 1);
  localparam logic [CNT_W-1:0] TO_TERM  = CNT_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(IDLE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t           state;
  logic             grant;
  logic             last_grant;
  logic             next_grant;
  logic [CNT_W-1:0] to_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             in_cmd;
  logic             in_data;

  // On a tie the port that was not served last wins. Otherwise the single requester wins.
  always_comb begin
    next_grant = r1_cmd_valid;
    if (r0_cmd_valid && r1_cmd_valid) begin
      next_grant = ~last_grant;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      to_cnt     <= '0;
      gap_cnt    <= '0;
      r0_done    <= 1'b0;
      r1_done    <= 1'b0;
      r0_err     <= 1'b0;
      r1_err     <= 1'b0;
      mem_abort  <= 1'b0;
    end else begin
      r0_done   <= 1'b0;
      r1_done   <= 1'b0;
      r0_err    <= 1'b0;
      r1_err    <= 1'b0;
      mem_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (r0_cmd_valid || r1_cmd_valid) begin
            grant      <= next_grant;
            last_grant <= next_grant;
            state      <= CMD;
          end
        end
        CMD: begin
          if (mem_cmd_ready) begin
            to_cnt <= '0;
            state  <= DATA;
          end
        end
        DATA: begin
          // A completion that coincides with the terminal count is a normal completion.
          if (mem_done) begin
            r0_done <= ~grant;
            r1_done <= grant;
            gap_cnt <= '0;
            state   <= GAP;
          end else if (to_cnt == TO_TERM) begin
            r0_done   <= ~grant;
            r1_done   <= grant;
            r0_err    <= ~grant;
            r1_err    <= grant;
            mem_abort <= 1'b1;
            gap_cnt   <= '0;
            state     <= GAP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_cmd  = (state == CMD);
  assign in_data = (state == DATA);

  // Command path is a straight mux of the granted port while in CMD.
  assign mem_cmd_valid = in_cmd;
  assign mem_cmd_write = in_cmd & (grant ? r1_cmd_write : r0_cmd_write);
  assign mem_cmd_addr  = in_cmd ? (grant ? r1_cmd_addr : r0_cmd_addr) : '0;
  assign mem_cmd_len   = in_cmd ? (grant ? r1_cmd_len : r0_cmd_len) : '0;
  assign r0_cmd_ready  = in_cmd & ~grant & mem_cmd_ready;
  assign r1_cmd_ready  = in_cmd & grant & mem_cmd_ready;

  // Zero-latency write and read data paths. They are gated so the idle port sees nothing.
  assign mem_wdata_valid = in_data & (grant ? r1_wdata_valid : r0_wdata_valid);
  assign mem_wdata       = in_data ? (grant ? r1_wdata : r0_wdata) : '0;
  assign r0_wdata_ready  = in_data & ~grant & mem_wdata_ready;
  assign r1_wdata_ready  = in_data & grant & mem_wdata_ready;

  assign r0_rdata_valid = in_data & ~grant & mem_rdata_valid;
  assign r1_rdata_valid = in_data & grant & mem_rdata_valid;
  assign r0_rdata       = (in_data & ~grant) ? mem_rdata : '0;
  assign r1_rdata       = (in_data & grant) ? mem_rdata : '0;

  assign dbg_state = state;
  assign dbg_grant = grant;

endmodule
